result_display_sequencer: RTL

- Downstream consumer of the systolic array result stream on the iCEBreaker top.
- Collects depth_p result words through a valid/ready handshake, then enters a display phase.
- In the display phase it presents each stored word on a display bus for a programmable dwell time, or until a manual advance, then returns to collecting.
- Replaces the ad-hoc fifo, display flag, five-second divider and edge-detect glue with one self-contained FSM.

---
 rtl/result_display_pkg.sv | 9 +
 rtl/result_display_sequencer_dwell_timer.sv | 37 +++
 rtl/result_display_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/result_display_pkg.sv
// Shared types for the result display sequencer: the two-phase collect/show state.
package result_display_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/result_display_sequencer_dwell_timer.sv
// Dwell counter for one displayed word; expire_o marks the last cycle of the dwell.
module dwell_timer #(
  parameter int dwell_cycles_p = 60000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CountW = (dwell_cycles_p > 1) ? $clog2(dwell_cycles_p) : 1;
  localparam logic [CountW-1:0] LastCount = CountW'(dwell_cycles_p - 1);

  logic [CountW-1:0] count_q, count_d;

  // clear wins over enable so a word boundary always restarts from zero
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i & (count_q == LastCount);

endmodule

// File: rtl/result_display_sequencer.sv
// Collects depth_p result words, then shows each one for a dwell time (or until advance_i).
module result_display_sequencer
  import result_display_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int depth_p        = 4,
  parameter int dwell_cycles_p = 60000000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  input  logic                       advance_i,
  input  logic                       flush_i,
  output logic                       display_o,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(depth_p)-1:0] index_o,
  output logic                       done_o
);

  localparam int IdxW = $clog2(depth_p);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(depth_p - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    wrIdx_q, wrIdx_d;
  logic [IdxW-1:0]    rdIdx_q, rdIdx_d;
  logic [width_p-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic [width_p-1:0] mem_q [depth_p];

  logic accept;
  logic wordEnd;
  logic expire;
  logic timerClear;

  assign ready_o    = (state_q == FILL) & ~reset_i & ~flush_i;
  assign accept     = valid_i & ready_o;
  assign wordEnd    = (state_q == SHOW) & (expire | advance_i);
  assign timerClear = flush_i | (state_q != SHOW) | wordEnd;

  dwell_timer #(
    .dwell_cycles_p(dwell_cycles_p)
  ) u_dwell_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timerClear),
    .en_i    (state_q == SHOW),
    .expire_o(expire)
  );

  // flush overrides both the accept path and every SHOW transition
  always_comb begin
    state_d = state_q;
    wrIdx_d = wrIdx_q;
    rdIdx_d = rdIdx_q;
    done_d  = 1'b0;
    if (flush_i) begin
      state_d = FILL;
      wrIdx_d = '0;
      rdIdx_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (wrIdx_q == LastIdx) begin
              state_d = SHOW;
              wrIdx_d = '0;
              rdIdx_d = '0;
            end else begin
              wrIdx_d = wrIdx_q + 1'b1;
            end
          end
        end
        SHOW: begin
          if (wordEnd) begin
            if (rdIdx_q == LastIdx) begin
              state_d = FILL;
              rdIdx_d = '0;
              done_d  = 1'b1;
            end else begin
              rdIdx_d = rdIdx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = FILL;
          wrIdx_d = '0;
          rdIdx_d = '0;
        end
      endcase
    end
  end

  // mem[0] is always written well before SHOW is entered, so the lookahead read is safe
  always_comb begin
    data_d = '0;
    if (state_d == SHOW) begin
      data_d = mem_q[rdIdx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FILL;
      wrIdx_q <= '0;
      rdIdx_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrIdx_q <= wrIdx_d;
      rdIdx_q <= rdIdx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wrIdx_q] <= data_i;
    end
  end

  assign display_o = (state_q == SHOW);
  assign data_o    = data_q;
  assign index_o   = rdIdx_q;
  assign done_o    = done_q;

endmodule
